// File: rtl/cpu_exec_sched.sv
// Queued opcode scheduler: FIFO of 4-bit opcodes issued one at a time to the control FSM.
// Optional flag-based stop on completion is enabled by defining CPU_SCHED_FLAG_STOP_EN.
module cpu_exec_sched #(
  parameter int DEPTH = 8,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_valid_i,
  input  logic [3:0]               push_op_i,
  output logic                     push_ready_o,
  input  logic                     run_i,
  input  logic                     abort_i,
  input  logic                     clear_i,
  output logic                     issue_valid_o,
  output logic [3:0]               issue_op_o,
  input  logic                     issue_ready_i,
  input  logic                     exec_done_i,
  input  logic [3:0]               flags_i,
`ifdef CPU_SCHED_FLAG_STOP_EN
  input  logic [3:0]               stop_mask_i,
  output logic                     stop_hit_o,
`endif
  output logic                     busy_o,
  output logic                     halted_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [7:0]               exec_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic [3:0]      op_q;
  logic [7:0]      exec_q;
  logic [3:0]      head;
  logic            clear_ok, push_acc, pop, done_acc, stop_now;

  assign head         = mem[rd_ptr];
  assign clear_ok     = clear_i && (state_q == S_IDLE || state_q == S_HALT);
  assign push_ready_o = (count_q != FULL_COUNT);
  assign push_acc     = push_valid_i && push_ready_o && !clear_ok;
  assign pop          = (state_q == S_FETCH);
  assign done_acc     = (state_q == S_WAIT) && exec_done_i && !abort_i;

`ifdef CPU_SCHED_FLAG_STOP_EN
  logic stop_hit_q;
  assign stop_now   = done_acc && ((flags_i & stop_mask_i) != 4'b0000);
  assign stop_hit_o = stop_hit_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                    stop_hit_q <= 1'b0;
    else if (stop_now)            stop_hit_q <= 1'b1;
    else if (run_i || clear_ok)   stop_hit_q <= 1'b0;
  end
`else
  logic unused_flags;
  assign unused_flags = ^flags_i;
  assign stop_now     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (clear_ok)                        state_d = S_IDLE;
        else if (run_i && count_q != '0)     state_d = S_FETCH;
      end
      S_FETCH: state_d = (head == HALT_OP) ? S_HALT : S_ISSUE;
      S_ISSUE: if (issue_ready_i) state_d = S_WAIT;
      S_WAIT: begin
        if (exec_done_i) begin
          if (stop_now)                          state_d = S_HALT;
          else if (count_q != '0 || push_acc)    state_d = S_FETCH;
          else                                   state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every in-flight transition, including a same-cycle handshake.
    if (abort_i && (state_q == S_FETCH || state_q == S_ISSUE || state_q == S_WAIT))
      state_d = S_HALT;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      op_q    <= '0;
      exec_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) op_q <= head;
      if (clear_ok) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
        exec_q  <= '0;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + AW'(1);
        if (pop)      rd_ptr <= rd_ptr + AW'(1);
        if (push_acc && !pop)      count_q <= count_q + CW'(1);
        else if (!push_acc && pop) count_q <= count_q - CW'(1);
        if (done_acc && exec_q != 8'hFF) exec_q <= exec_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wr_ptr] <= push_op_i;
  end

  assign issue_valid_o = (state_q == S_ISSUE);
  assign issue_op_o    = issue_valid_o ? op_q : 4'h0;
  assign busy_o        = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign halted_o      = (state_q == S_HALT);
  assign fifo_count_o  = count_q;
  assign exec_count_o  = exec_q;

endmodule

// File: tb/tb_cpu_exec_sched.sv
// Self-checking bench for cpu_exec_sched: issued opcodes go through a scoreboard queue,
// status outputs are checked against hand-computed values after each directed step.
module tb_cpu_exec_sched;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       push_valid_i = 1'b0;
  logic [3:0] push_op_i = 4'h0;
  logic       push_ready_o;
  logic       run_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       issue_valid_o;
  logic [3:0] issue_op_o;
  logic       issue_ready_i = 1'b0;
  logic       exec_done_i = 1'b0;
  logic [3:0] flags_i = 4'h0;
  logic       busy_o;
  logic       halted_o;
  logic [3:0] fifo_count_o;
  logic [7:0] exec_count_o;
`ifdef CPU_SCHED_FLAG_STOP_EN
  logic [3:0] stop_mask_i = 4'h0;
  logic       stop_hit_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] exp_q [$];

  cpu_exec_sched dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_valid_i(push_valid_i), .push_op_i(push_op_i), .push_ready_o(push_ready_o),
    .run_i(run_i), .abort_i(abort_i), .clear_i(clear_i),
    .issue_valid_o(issue_valid_o), .issue_op_o(issue_op_o), .issue_ready_i(issue_ready_i),
    .exec_done_i(exec_done_i), .flags_i(flags_i),
`ifdef CPU_SCHED_FLAG_STOP_EN
    .stop_mask_i(stop_mask_i), .stop_hit_o(stop_hit_o),
`endif
    .busy_o(busy_o), .halted_o(halted_o),
    .fifo_count_o(fifo_count_o), .exec_count_o(exec_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Handshakes are sampled mid-cycle, before the edge that consumes them.
  always @(negedge clk_i) begin
    if (!rst_i && issue_valid_o && issue_ready_i) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL issue_unexpected: got op %0h, expected none", issue_op_o);
      end else begin
        check("issue_op", int'(issue_op_o), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [3:0] op);
    push_valid_i = 1'b1;
    push_op_i = op;
    tick();
    push_valid_i = 1'b0;
  endtask

  task automatic pulse_run();
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (issue_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("issue_timeout", 0, 1);
  endtask

  task automatic issue_op(input logic [3:0] op);
    bit ok;
    wait_valid(ok);
    if (ok) begin
      exp_q.push_back(op);
      issue_ready_i = 1'b1;
      tick();
      issue_ready_i = 1'b0;
    end
  endtask

  task automatic done_pulse(input logic [3:0] flags);
    exec_done_i = 1'b1;
    flags_i = flags;
    tick();
    exec_done_i = 1'b0;
    flags_i = 4'h0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_fifo_count"}, int'(fifo_count_o), 0);
    check({tag, "_push_ready"}, int'(push_ready_o), 1);
    check({tag, "_exec_count"}, int'(exec_count_o), 0);
    check({tag, "_issue_valid"}, int'(issue_valid_o), 0);
    check({tag, "_issue_op"}, int'(issue_op_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_halted"}, int'(halted_o), 0);
  endtask

  initial begin
    bit ok;
    tick();
    tick();
    rst_i = 1'b0;
    check_reset_values("reset");

    // Program 3,5,HALT,2: two executions, then halt with opcode 2 left behind.
    push(4'h3); push(4'h5); push(4'hF); push(4'h2);
    check("prog_fifo_count", int'(fifo_count_o), 4);
    pulse_run();
    check("fetch_valid_low", int'(issue_valid_o), 0);
    check("fetch_busy", int'(busy_o), 1);
    tick();
    check("run_latency_valid", int'(issue_valid_o), 1);
    tick(); tick();
    check("hold_op3", int'(issue_op_o), 3);
    issue_op(4'h3);
    check("wait_valid_low", int'(issue_valid_o), 0);
    done_pulse(4'h0);
    issue_op(4'h5);
    done_pulse(4'h0);
    tick();
    check("prog_halted", int'(halted_o), 1);
    check("prog_exec_count", int'(exec_count_o), 2);
    check("prog_fifo_left", int'(fifo_count_o), 1);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clear_fifo", int'(fifo_count_o), 0);
    check("clear_exec", int'(exec_count_o), 0);
    check("clear_idle", int'(halted_o), 0);

    // Fill to full, drop the ninth push, then drain all eight.
    for (int i = 1; i <= 8; i++) push(4'(i));
    check("full_count", int'(fifo_count_o), 8);
    check("full_ready", int'(push_ready_o), 0);
    push(4'h9);
    check("full_drop_count", int'(fifo_count_o), 8);
    pulse_run();
    for (int i = 1; i <= 8; i++) begin
      issue_op(4'(i));
      done_pulse(4'h0);
    end
    tick();
    check("drain_halted", int'(halted_o), 1);
    check("drain_exec", int'(exec_count_o), 8);
    check("drain_fifo", int'(fifo_count_o), 0);
    clear_i = 1'b1; tick(); clear_i = 1'b0;

    // Ten-cycle stall on ready, then abort in WAIT and resume.
    push(4'h7); push(4'h4);
    pulse_run();
    wait_valid(ok);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", int'(issue_valid_o), 1);
      check("stall_op", int'(issue_op_o), 7);
      tick();
    end
    issue_op(4'h7);
    done_pulse(4'h0);
    check("stall_exec_once", int'(exec_count_o), 1);
    push(4'h6);
    issue_op(4'h4);
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    check("abort_halted", int'(halted_o), 1);
    check("abort_exec", int'(exec_count_o), 1);
    check("abort_fifo", int'(fifo_count_o), 1);
    done_pulse(4'h0);
    check("stray_done_exec", int'(exec_count_o), 1);
    pulse_run();
    issue_op(4'h6);
    done_pulse(4'h0);
    tick();
    check("resume_exec", int'(exec_count_o), 2);
    check("resume_halted", int'(halted_o), 1);

    // Clear is ignored in WAIT and honoured in HALT.
    push(4'h2); push(4'h3);
    pulse_run();
    issue_op(4'h2);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clear_wait_busy", int'(busy_o), 1);
    check("clear_wait_fifo", int'(fifo_count_o), 1);
    check("clear_wait_exec", int'(exec_count_o), 2);
    done_pulse(4'h0);
    issue_op(4'h3);
    done_pulse(4'h0);
    tick();
    check("clear_seq_exec", int'(exec_count_o), 4);
    check("clear_seq_halted", int'(halted_o), 1);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check_reset_values("clear_halt");

    // Reset while an opcode is being presented.
    push(4'h9);
    pulse_run();
    wait_valid(ok);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check_reset_values("reset_issue");

`ifdef CPU_SCHED_FLAG_STOP_EN
    stop_mask_i = 4'b0010;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    pulse_run();
    issue_op(4'h1);
    done_pulse(4'b0000);
    issue_op(4'h2);
    done_pulse(4'b0010);
    check("stop_halted", int'(halted_o), 1);
    check("stop_hit", int'(stop_hit_o), 1);
    check("stop_fifo", int'(fifo_count_o), 2);
    check("stop_exec", int'(exec_count_o), 2);
`endif

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
